// File: rtl/mmio_cr_gpio_pkg.sv
// Shared definitions for the control-register GPIO block: opcode type,
// control-region decode constants and register offsets.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2
  } t_opcode;

  // Requests whose address[MSB_REGION:LSB_REGION] equals CR_REGION belong to us.
  localparam int MSB_REGION = 31;
  localparam int LSB_REGION = 20;
  localparam logic [MSB_REGION-LSB_REGION:0] CR_REGION = 12'h0C2;

  // Register offsets within the region (address[19:0]).
  localparam logic [19:0] CR_GPIO_SEG7_BASE    = 20'h00000;
  localparam logic [19:0] CR_GPIO_LED          = 20'h00100;
  localparam logic [19:0] CR_GPIO_IN_SYNC      = 20'h00104;
  localparam logic [19:0] CR_GPIO_IN_DEB       = 20'h00108;
  localparam logic [19:0] CR_GPIO_RISE         = 20'h0010C;
  localparam logic [19:0] CR_GPIO_FALL         = 20'h00110;
  localparam logic [19:0] CR_GPIO_IRQ_MASK     = 20'h00114;
  localparam logic [19:0] CR_GPIO_ALL_PC_RESET = 20'h00118;
  localparam logic [19:0] CR_GPIO_DB_THRESH    = 20'h0011C;

  // True when a byte address falls inside the control-register region.
  function automatic logic cr_region_hit(input logic [31:0] addr);
    return (addr[MSB_REGION:LSB_REGION] == CR_REGION);
  endfunction

endpackage

// File: rtl/mmio_cr_gpio_if.sv
// Request/response bus between the fabric (master) and the GPIO block (slave).
interface mmio_cr_gpio_if;
  import lotr_pkg::*;

  logic        F2C_ReqValidQ502H;
  t_opcode     F2C_ReqOpcodeQ502H;
  logic [31:0] F2C_ReqAddressQ502H;
  logic [31:0] F2C_ReqDataQ502H;
  logic        F2C_RspValidQ500H;
  t_opcode     F2C_RspOpcodeQ500H;
  logic [31:0] F2C_RspAddressQ500H;
  logic [31:0] F2C_RspDataQ500H;

  modport master (
    output F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
    input  F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H
  );

  modport slave (
    input  F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
    output F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H
  );

endinterface

// File: rtl/mmio_cr_gpio_debounce.sv
// One input bit: 2-flop synchronizer, saturating-counter debouncer and
// edge detector. A zero threshold turns the debouncer into a plain 1-cycle delay.
module gpio_debounce #(
  parameter int DB_W = 16
) (
  input  logic            QClk,
  input  logic            RstQnnnH,
  input  logic            async_in,
  input  logic [DB_W-1:0] db_thresh,
  output logic            in_sync,
  output logic            in_deb,
  output logic            rise,
  output logic            fall
);

  logic            sync1_r;
  logic            sync2_r;
  logic            deb_r;
  logic            rise_r;
  logic            fall_r;
  logic [DB_W-1:0] cnt_r;
  logic [DB_W-1:0] cnt_inc_s;
  logic [DB_W-1:0] cnt_next_s;
  logic            deb_next_s;

  // Saturating increment so a long mismatch never wraps the counter.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r == {DB_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + DB_W'(1'b1);
    end
  end

  // Next debounced level and counter value.
  always_comb begin
    deb_next_s = deb_r;
    cnt_next_s = cnt_r;
    if (db_thresh == {DB_W{1'b0}}) begin
      deb_next_s = sync2_r;
      cnt_next_s = {DB_W{1'b0}};
    end else if (sync2_r == deb_r) begin
      deb_next_s = deb_r;
      cnt_next_s = {DB_W{1'b0}};
    end else if (cnt_inc_s >= db_thresh) begin
      deb_next_s = sync2_r;
      cnt_next_s = {DB_W{1'b0}};
    end else begin
      deb_next_s = deb_r;
      cnt_next_s = cnt_inc_s;
    end
  end

  // Synchronizer, debounce state and registered edge pulses.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= {DB_W{1'b0}};
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      deb_r   <= deb_next_s;
      cnt_r   <= cnt_next_s;
      rise_r  <= deb_next_s & ~deb_r;
      fall_r  <= ~deb_next_s & deb_r;
    end
  end

  assign in_sync = sync2_r;
  assign in_deb  = deb_r;
  assign rise    = rise_r;
  assign fall    = fall_r;

endmodule

// File: rtl/mmio_cr_gpio.sv
// Control-register GPIO block: seven-segment, LED and core-reset registers,
// debounced inputs with sticky edge status and a masked interrupt. Requests
// flow through a fixed 3-stage pipeline (503, 504, 500) so every claimed
// request gets exactly one response three cycles later.
module mmio_cr_gpio
  import lotr_pkg::*;
#(
  parameter int N_SEG7 = 6,
  parameter int LED_W  = 10,
  parameter int IN_W   = 16,
  parameter int DB_W   = 16
) (
  input  logic                QClk,
  input  logic                RstQnnnH,
  mmio_cr_gpio_if.slave       f2c,
  input  logic [IN_W-1:0]     GpioIn,
  output logic [N_SEG7*8-1:0] SEG7,
  output logic [LED_W-1:0]    LED,
  output logic                ALL_PC_RESET,
  output logic                IrqOut
);

  // Pipeline state
  logic        v503_r;
  t_opcode     op503_r;
  logic [31:0] addr503_r;
  logic [31:0] wdata503_r;
  logic        v504_r;
  logic [31:0] addr504_r;
  logic [31:0] rdata504_r;
  logic        rsp_v_r;
  logic [31:0] rsp_addr_r;
  logic [31:0] rsp_data_r;

  // Architectural registers
  logic [7:0]      seg_r [N_SEG7];
  logic [LED_W-1:0] led_r;
  logic [IN_W-1:0]  mask_r;
  logic [IN_W-1:0]  rise_r;
  logic [IN_W-1:0]  fall_r;
  logic             apcr_r;
  logic [DB_W-1:0]  thresh_r;

  // Registered outputs
  logic [N_SEG7*8-1:0] seg_out_r;
  logic [LED_W-1:0]    led_out_r;
  logic                apcr_out_r;
  logic                irq_r;

  // Per-bit input datapath
  logic [IN_W-1:0] in_sync_s;
  logic [IN_W-1:0] in_deb_s;
  logic [IN_W-1:0] rise_ev_s;
  logic [IN_W-1:0] fall_ev_s;

  // Decode of the request sitting in stage 503
  logic            claim_s;
  logic [19:0]     off_s;
  logic [2:0]      seg_idx_s;
  logic            seg_hit_s;
  logic            wr_s;
  logic            rd_s;
  logic [31:0]     rd_mux_s;
  logic [IN_W-1:0] rise_clr_s;
  logic [IN_W-1:0] fall_clr_s;

  assign claim_s   = f2c.F2C_ReqValidQ502H && cr_region_hit(f2c.F2C_ReqAddressQ502H);
  assign off_s     = addr503_r[19:0];
  assign seg_idx_s = off_s[4:2];
  assign wr_s      = v503_r && (op503_r == WR);
  assign rd_s      = v503_r && (op503_r == RD);

  // A SEG7 offset is word-aligned, below 0x20 and names an existing digit.
  always_comb begin
    seg_hit_s = 1'b0;
    if ((off_s[19:5] == 15'd0) && (off_s[1:0] == 2'd0) && (int'(seg_idx_s) < N_SEG7)) begin
      seg_hit_s = 1'b1;
    end else begin
      seg_hit_s = 1'b0;
    end
  end

  // Read mux; unmapped offsets and bits above a register's width read 0.
  always_comb begin
    rd_mux_s = 32'd0;
    if (seg_hit_s) begin
      rd_mux_s[7:0] = seg_r[seg_idx_s];
    end else begin
      case (off_s)
        CR_GPIO_LED:          rd_mux_s[LED_W-1:0] = led_r;
        CR_GPIO_IN_SYNC:      rd_mux_s[IN_W-1:0]  = in_sync_s;
        CR_GPIO_IN_DEB:       rd_mux_s[IN_W-1:0]  = in_deb_s;
        CR_GPIO_RISE:         rd_mux_s[IN_W-1:0]  = rise_r;
        CR_GPIO_FALL:         rd_mux_s[IN_W-1:0]  = fall_r;
        CR_GPIO_IRQ_MASK:     rd_mux_s[IN_W-1:0]  = mask_r;
        CR_GPIO_ALL_PC_RESET: rd_mux_s[0]         = apcr_r;
        CR_GPIO_DB_THRESH:    rd_mux_s[DB_W-1:0]  = thresh_r;
        default:              rd_mux_s            = 32'd0;
      endcase
    end
  end

  // Write-one-to-clear masks for the sticky edge status.
  always_comb begin
    rise_clr_s = {IN_W{1'b0}};
    fall_clr_s = {IN_W{1'b0}};
    if (wr_s && (off_s == CR_GPIO_RISE)) begin
      rise_clr_s = wdata503_r[IN_W-1:0];
    end else begin
      rise_clr_s = {IN_W{1'b0}};
    end
    if (wr_s && (off_s == CR_GPIO_FALL)) begin
      fall_clr_s = wdata503_r[IN_W-1:0];
    end else begin
      fall_clr_s = {IN_W{1'b0}};
    end
  end

  // Request pipeline 502 -> 503 -> 504 -> 500; read data is captured from
  // the registers before the same edge applies any write.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      v503_r     <= 1'b0;
      op503_r    <= RD;
      addr503_r  <= 32'd0;
      wdata503_r <= 32'd0;
      v504_r     <= 1'b0;
      addr504_r  <= 32'd0;
      rdata504_r <= 32'd0;
      rsp_v_r    <= 1'b0;
      rsp_addr_r <= 32'd0;
      rsp_data_r <= 32'd0;
    end else begin
      v503_r     <= claim_s;
      op503_r    <= f2c.F2C_ReqOpcodeQ502H;
      addr503_r  <= f2c.F2C_ReqAddressQ502H;
      wdata503_r <= f2c.F2C_ReqDataQ502H;
      v504_r     <= v503_r;
      addr504_r  <= addr503_r;
      rdata504_r <= rd_s ? rd_mux_s : 32'd0;
      rsp_v_r    <= v504_r;
      rsp_addr_r <= addr504_r;
      rsp_data_r <= rdata504_r;
    end
  end

  // Register file updates at the 503->504 edge; an edge event beats a
  // simultaneous clear so no event is lost.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      for (int i = 0; i < N_SEG7; i++) begin
        seg_r[i] <= 8'd0;
      end
      led_r    <= {LED_W{1'b0}};
      mask_r   <= {IN_W{1'b0}};
      rise_r   <= {IN_W{1'b0}};
      fall_r   <= {IN_W{1'b0}};
      apcr_r   <= 1'b0;
      thresh_r <= {DB_W{1'b1}};
    end else begin
      if (wr_s && seg_hit_s) begin
        seg_r[seg_idx_s] <= wdata503_r[7:0];
      end
      if (wr_s && (off_s == CR_GPIO_LED)) begin
        led_r <= wdata503_r[LED_W-1:0];
      end
      if (wr_s && (off_s == CR_GPIO_IRQ_MASK)) begin
        mask_r <= wdata503_r[IN_W-1:0];
      end
      if (wr_s && (off_s == CR_GPIO_ALL_PC_RESET)) begin
        apcr_r <= wdata503_r[0];
      end
      if (wr_s && (off_s == CR_GPIO_DB_THRESH)) begin
        thresh_r <= wdata503_r[DB_W-1:0];
      end
      rise_r <= (rise_r & ~rise_clr_s) | rise_ev_s;
      fall_r <= (fall_r & ~fall_clr_s) | fall_ev_s;
    end
  end

  // Output copies of the registers and the masked interrupt summary.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      seg_out_r  <= {(N_SEG7*8){1'b0}};
      led_out_r  <= {LED_W{1'b0}};
      apcr_out_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      for (int i = 0; i < N_SEG7; i++) begin
        seg_out_r[8*i +: 8] <= seg_r[i];
      end
      led_out_r  <= led_r;
      apcr_out_r <= apcr_r;
      irq_r      <= |((rise_r | fall_r) & mask_r);
    end
  end

  for (genvar b = 0; b < IN_W; b++) begin : g_bit
    gpio_debounce #(
      .DB_W(DB_W)
    ) u_db (
      .QClk      (QClk),
      .RstQnnnH  (RstQnnnH),
      .async_in  (GpioIn[b]),
      .db_thresh (thresh_r),
      .in_sync   (in_sync_s[b]),
      .in_deb    (in_deb_s[b]),
      .rise      (rise_ev_s[b]),
      .fall      (fall_ev_s[b])
    );
  end

  assign f2c.F2C_RspValidQ500H   = rsp_v_r;
  assign f2c.F2C_RspOpcodeQ500H  = RD_RSP;
  assign f2c.F2C_RspAddressQ500H = rsp_addr_r;
  assign f2c.F2C_RspDataQ500H    = rsp_data_r;

  assign SEG7         = seg_out_r;
  assign LED          = led_out_r;
  assign ALL_PC_RESET = apcr_out_r;
  assign IrqOut       = irq_r;

endmodule

// File: tb/tb_mmio_cr_gpio.sv
// Directed self-checking bench for mmio_cr_gpio with default parameters.
module tb_mmio_cr_gpio;
  import lotr_pkg::*;

  localparam logic [31:0] BASE  = 32'h0C20_0000;
  localparam logic [31:0] OTHER = 32'h0C30_0008;

  logic        QClk = 1'b0;
  logic        RstQnnnH;
  logic [15:0] GpioIn;
  logic [47:0] SEG7;
  logic [9:0]  LED;
  logic        ALL_PC_RESET;
  logic        IrqOut;

  int checks = 0;
  int errors = 0;

  mmio_cr_gpio_if bus ();

  mmio_cr_gpio dut (
    .QClk         (QClk),
    .RstQnnnH     (RstQnnnH),
    .f2c          (bus),
    .GpioIn       (GpioIn),
    .SEG7         (SEG7),
    .LED          (LED),
    .ALL_PC_RESET (ALL_PC_RESET),
    .IrqOut       (IrqOut)
  );

  always #5 QClk = ~QClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (called #1 after a rising edge) and watch 6 cycles.
  task automatic do_req(input t_opcode op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [31:0] raddr,
                        output int lat, output int nrsp);
    bus.F2C_ReqValidQ502H   = 1'b1;
    bus.F2C_ReqOpcodeQ502H  = op;
    bus.F2C_ReqAddressQ502H = addr;
    bus.F2C_ReqDataQ502H    = wdata;
    @(posedge QClk);
    #1;
    bus.F2C_ReqValidQ502H = 1'b0;
    lat = -1;
    nrsp = 0;
    rdata = 32'hDEAD_BEEF;
    raddr = 32'hDEAD_BEEF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge QClk);
      if (bus.F2C_RspValidQ500H === 1'b1) begin
        nrsp++;
        if (lat < 0) begin
          lat = k;
          rdata = bus.F2C_RspDataQ500H;
          raddr = bus.F2C_RspAddressQ500H;
          chk("rsp_opcode", 32'(bus.F2C_RspOpcodeQ500H), 32'(RD_RSP));
        end
      end
    end
    @(posedge QClk);
    #1;
  endtask

  task automatic access(input string tag, input t_opcode op, input logic [19:0] off,
                        input logic [31:0] wdata, input logic [31:0] exp_data);
    logic [31:0] rdata;
    logic [31:0] raddr;
    int lat;
    int nrsp;
    do_req(op, BASE | {12'd0, off}, wdata, rdata, raddr, lat, nrsp);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_nrsp"}, 32'(nrsp), 32'd1);
    chk({tag, "_addr"}, raddr, BASE | {12'd0, off});
    chk({tag, "_data"}, rdata, exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdata;
    logic [31:0] raddr;
    int lat;
    int nrsp;
    int cnt;

    RstQnnnH = 1'b1;
    GpioIn = 16'h0000;
    bus.F2C_ReqValidQ502H   = 1'b0;
    bus.F2C_ReqOpcodeQ502H  = RD;
    bus.F2C_ReqAddressQ502H = 32'd0;
    bus.F2C_ReqDataQ502H    = 32'd0;
    repeat (3) @(posedge QClk);
    #1;
    RstQnnnH = 1'b0;
    @(negedge QClk);
    chk("rst_rsp_valid", 32'(bus.F2C_RspValidQ500H), 32'd0);
    chk("rst_seg7", SEG7[31:0], 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_apcr", 32'(ALL_PC_RESET), 32'd0);
    chk("rst_irq", 32'(IrqOut), 32'd0);
    @(posedge QClk);
    #1;
    access("rst_thresh", RD, CR_GPIO_DB_THRESH, 32'd0, 32'h0000_FFFF);

    // SEG7 digit 2 write then read back
    access("seg2_wr", WR, 20'h00008, 32'h0000_003F, 32'd0);
    access("seg2_rd", RD, 20'h00008, 32'd0, 32'h0000_003F);
    chk("seg7_out2", 32'(SEG7[23:16]), 32'h0000_003F);

    // Bits above LED width are dropped
    access("led_wr", WR, CR_GPIO_LED, 32'hFFFF_FFFF, 32'd0);
    access("led_rd", RD, CR_GPIO_LED, 32'd0, 32'h0000_03FF);
    chk("led_out", 32'(LED), 32'h0000_03FF);

    // Back-to-back: write LED, read LED (new value), read SEG7 digit 2
    bus.F2C_ReqValidQ502H = 1'b1;
    bus.F2C_ReqOpcodeQ502H = WR;
    bus.F2C_ReqAddressQ502H = BASE | 32'h100;
    bus.F2C_ReqDataQ502H = 32'h0000_0155;
    @(posedge QClk); #1;
    bus.F2C_ReqOpcodeQ502H = RD;
    @(posedge QClk); #1;
    bus.F2C_ReqAddressQ502H = BASE | 32'h008;
    @(posedge QClk); #1;
    bus.F2C_ReqValidQ502H = 1'b0;
    @(negedge QClk);
    chk("b2b0_valid", 32'(bus.F2C_RspValidQ500H), 32'd1);
    chk("b2b0_data", bus.F2C_RspDataQ500H, 32'd0);
    @(negedge QClk);
    chk("b2b1_valid", 32'(bus.F2C_RspValidQ500H), 32'd1);
    chk("b2b1_data", bus.F2C_RspDataQ500H, 32'h0000_0155);
    @(negedge QClk);
    chk("b2b2_valid", 32'(bus.F2C_RspValidQ500H), 32'd1);
    chk("b2b2_data", bus.F2C_RspDataQ500H, 32'h0000_003F);
    @(negedge QClk);
    chk("b2b3_valid", 32'(bus.F2C_RspValidQ500H), 32'd0);
    chk("b2b_led_out", 32'(LED), 32'h0000_0155);
    @(posedge QClk); #1;

    // Unmapped offsets and foreign region
    access("seg7_hole", WR, 20'h0001C, 32'h0000_00AA, 32'd0);
    access("seg7_hole_rd", RD, 20'h0001C, 32'd0, 32'd0);
    access("unmapped_rd", RD, 20'h00200, 32'd0, 32'd0);
    do_req(RD, OTHER, 32'd0, rdata, raddr, lat, nrsp);
    chk("foreign_nrsp", 32'(nrsp), 32'd0);

    // Debounce with threshold 4: a 3-cycle glitch is rejected
    access("thresh4", WR, CR_GPIO_DB_THRESH, 32'h0000_0004, 32'd0);
    GpioIn = 16'h0001;
    repeat (3) @(posedge QClk);
    #1;
    GpioIn = 16'h0000;
    repeat (10) @(posedge QClk);
    #1;
    access("glitch_deb", RD, CR_GPIO_IN_DEB, 32'd0, 32'd0);
    access("glitch_rise", RD, CR_GPIO_RISE, 32'd0, 32'd0);
    GpioIn = 16'h0001;
    repeat (10) @(posedge QClk);
    #1;
    access("steady_sync", RD, CR_GPIO_IN_SYNC, 32'd0, 32'h0000_0001);
    access("steady_deb", RD, CR_GPIO_IN_DEB, 32'd0, 32'h0000_0001);
    access("steady_rise", RD, CR_GPIO_RISE, 32'd0, 32'h0000_0001);
    chk("irq_masked", 32'(IrqOut), 32'd0);
    access("mask_wr", WR, CR_GPIO_IRQ_MASK, 32'h0000_0001, 32'd0);
    chk("irq_unmasked", 32'(IrqOut), 32'd1);

    // Bypass debounce, then collide a W1C with a fresh rise
    access("thresh0", WR, CR_GPIO_DB_THRESH, 32'd0, 32'd0);
    GpioIn = 16'h0000;
    repeat (6) @(posedge QClk);
    #1;
    access("fall_rd", RD, CR_GPIO_FALL, 32'd0, 32'h0000_0001);
    access("rise_clr", WR, CR_GPIO_RISE, 32'h0000_0001, 32'd0);
    access("rise_cleared", RD, CR_GPIO_RISE, 32'd0, 32'd0);
    GpioIn = 16'h0001;
    @(posedge QClk);
    @(posedge QClk);
    #1;
    access("rise_collide", WR, CR_GPIO_RISE, 32'h0000_0001, 32'd0);
    access("rise_kept", RD, CR_GPIO_RISE, 32'd0, 32'h0000_0001);
    access("rise_clr2", WR, CR_GPIO_RISE, 32'h0000_0001, 32'd0);
    access("rise_gone", RD, CR_GPIO_RISE, 32'd0, 32'd0);

    access("apcr_wr", WR, CR_GPIO_ALL_PC_RESET, 32'h0000_0001, 32'd0);
    chk("apcr_out", 32'(ALL_PC_RESET), 32'd1);
    chk("irq_fall_pending", 32'(IrqOut), 32'd1);

    // Reset in the middle of a back-to-back burst
    bus.F2C_ReqValidQ502H = 1'b1;
    bus.F2C_ReqOpcodeQ502H = RD;
    bus.F2C_ReqAddressQ502H = BASE | 32'h100;
    @(posedge QClk); #1;
    bus.F2C_ReqAddressQ502H = BASE | 32'h008;
    @(posedge QClk); #1;
    bus.F2C_ReqAddressQ502H = BASE | 32'h118;
    RstQnnnH = 1'b1;
    @(posedge QClk); #1;
    bus.F2C_ReqAddressQ502H = BASE | 32'h11C;
    @(posedge QClk); #1;
    bus.F2C_ReqValidQ502H = 1'b0;
    @(negedge QClk);
    chk("mid_rst_valid", 32'(bus.F2C_RspValidQ500H), 32'd0);
    chk("mid_rst_seg7", SEG7[31:0], 32'd0);
    chk("mid_rst_led", 32'(LED), 32'd0);
    chk("mid_rst_apcr", 32'(ALL_PC_RESET), 32'd0);
    chk("mid_rst_irq", 32'(IrqOut), 32'd0);
    @(posedge QClk); #1;
    RstQnnnH = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge QClk);
      if (bus.F2C_RspValidQ500H !== 1'b0) cnt++;
    end
    chk("stale_rsp", 32'(cnt), 32'd0);
    @(posedge QClk); #1;
    access("post_rst_thresh", RD, CR_GPIO_DB_THRESH, 32'd0, 32'h0000_FFFF);
    access("post_rst_led", RD, CR_GPIO_LED, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
